// File: rtl/settings_fifo_master_if.sv
// settings_fifo_master_if
//   Bundles the request, command-packet, ACK-packet and readback signals of the
//   fifo36 settings initiator.
//   master : the initiator (settings_fifo_master) side
//   slave  : the requesting logic / link / remote side
//
//   cmd_*      request handshake (cmd_valid/cmd_ready) and request fields
//   out_*      command packet stream, fifo36 ([33]=EOF, [32]=SOF)
//   in_*       ACK packet stream, fifo36
//   rb_*       readback result, completion pulse and timeout pulse
//   busy       a transaction is in flight
interface settings_fifo_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_poke;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_has_time;
  logic [63:0] cmd_time;

  logic [35:0] out_data;
  logic        out_valid;
  logic        out_ready;

  logic [35:0] in_data;
  logic        in_valid;
  logic        in_ready;

  logic        rb_valid;
  logic [31:0] rb_data;
  logic        rb_timeout;
  logic        busy;

  modport master (
    input  cmd_valid, cmd_poke, cmd_addr, cmd_data, cmd_has_time, cmd_time,
    output cmd_ready,
    output out_data, out_valid,
    input  out_ready,
    input  in_data, in_valid,
    output in_ready,
    output rb_valid, rb_data, rb_timeout, busy
  );

  modport slave (
    output cmd_valid, cmd_poke, cmd_addr, cmd_data, cmd_has_time, cmd_time,
    input  cmd_ready,
    input  out_data, out_valid,
    output out_ready,
    output in_data, in_valid,
    input  in_ready,
    input  rb_valid, rb_data, rb_timeout, busy
  );
endinterface

// File: rtl/settings_fifo_master.sv
// settings_fifo_master
//   Initiator end of the fifo36 settings/readback protocol. One register access
//   (poke or peek, optionally timed) is accepted, emitted as a framed VITA command
//   packet, and completed when the matching ACK packet returns its readback word.
//   Only one transaction is outstanding at a time.
//
// Ports
//   clock      clock
//   reset      synchronous, active-high reset (also returns seq to 0)
//   clear      synchronous abort of the current transaction (seq is kept)
//   bus        settings_fifo_master_if.master:
//                cmd_*  request in, cmd_ready == ~busy
//                out_*  command packet out (fifo36)
//                in_*   ACK packet in (fifo36), in_ready tied high
//                rb_*   readback word / completion pulse / timeout pulse
//                busy   transaction in flight
//
// Parameters
//   XPORT_HDR  1: prepend a transport length line (bytes of the VITA packet)
//   PROT_HDR   1: ACK packets start with a protocol header line to skip
//   CMD_SID    stream ID written into command packets
//   TIMEOUT    cycles spent waiting for the ACK before abandoning; 0 disables
module settings_fifo_master #(
  parameter bit          XPORT_HDR = 1'b1,
  parameter bit          PROT_HDR  = 1'b1,
  parameter logic [31:0] CMD_SID   = 32'h0,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  settings_fifo_master_if.master        bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_XPORT,
    S_VHDR,
    S_SID,
    S_TSF0,
    S_TSF1,
    S_CHDR,
    S_DATA,
    S_WAIT_ACK
  } state_t;

  // Position of the readback header and of the final (EOF) line inside an ACK.
  localparam logic [2:0] ACK_RBH_IDX  = PROT_HDR ? 3'd3 : 3'd2;
  localparam logic [2:0] ACK_LAST_IDX = PROT_HDR ? 3'd4 : 3'd3;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  seq;

  // Latched request
  logic        poke_q;
  logic [7:0]  addr_q;
  logic [31:0] data_q;
  logic        has_time_q;
  logic [63:0] time_q;

  logic [31:0] to_cnt;
  logic [2:0]  ack_cnt;
  logic [3:0]  rb_seq_q;
  logic [8:0]  rb_sel_q;
  logic        rb_valid_q;
  logic [31:0] rb_data_q;

  logic [31:0] out_word;
  logic        out_sof;
  logic        out_eof;
  logic        out_vld;
  logic        accept;

  logic        in_sof;
  logic        in_eof;
  logic        ack_active;
  logic [2:0]  ack_idx;
  logic        ack_last;
  logic        ack_match;
  logic        expire;

  // The two spare fifo36 flag bits of ACK lines carry nothing we use.
  logic        unused_in_flags;
  assign unused_in_flags = ^bus.in_data[35:34];

  // ---------------------------------------------------------------------------
  // Handshakes and ACK line tracking
  // ---------------------------------------------------------------------------
  assign out_vld = (state != S_IDLE) && (state != S_WAIT_ACK);
  assign accept  = bus.cmd_valid && (state == S_IDLE) && !clear;

  assign in_sof  = bus.in_data[32];
  assign in_eof  = bus.in_data[33];

  // A line only belongs to a packet if it starts one (SOF) or a packet is
  // already open; stray lines between packets are ignored. A SOF always
  // restarts the count, which drops any packet it interrupted.
  assign ack_active = bus.in_valid && (in_sof || (ack_cnt != 3'd0));
  assign ack_idx    = in_sof ? 3'd0 : ack_cnt;
  assign ack_last   = ack_active && in_eof && (ack_idx == ACK_LAST_IDX);

  assign ack_match = ack_last && !clear && (state == S_WAIT_ACK) &&
                     (rb_seq_q == seq) && (rb_sel_q == {poke_q, addr_q});

  // A matching ACK in the expiry cycle takes precedence over the timeout.
  assign expire = (TIMEOUT != 0) && (state == S_WAIT_ACK) &&
                  (to_cnt == TIMEOUT) && !ack_match && !clear;

  // ---------------------------------------------------------------------------
  // TX FSM next state and command line formatting
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    out_word  = 32'h0;
    out_sof   = 1'b0;
    out_eof   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.cmd_valid) state_nxt = XPORT_HDR ? S_XPORT : S_VHDR;
      end
      S_XPORT: begin
        out_word = has_time_q ? 32'd24 : 32'd16;
        out_sof  = 1'b1;
        if (bus.out_ready) state_nxt = S_VHDR;
      end
      S_VHDR: begin
        // [28] SID present, [21:20] integer timestamp type, [19:16] seq,
        // [15:0] VITA packet length in words.
        out_word = {3'b000, 1'b1, 6'b0, (has_time_q ? 2'b01 : 2'b00), seq,
                    (has_time_q ? 16'd6 : 16'd4)};
        out_sof  = !XPORT_HDR;
        if (bus.out_ready) state_nxt = S_SID;
      end
      S_SID: begin
        out_word = CMD_SID;
        if (bus.out_ready) state_nxt = has_time_q ? S_TSF0 : S_CHDR;
      end
      S_TSF0: begin
        out_word = time_q[63:32];
        if (bus.out_ready) state_nxt = S_TSF1;
      end
      S_TSF1: begin
        out_word = time_q[31:0];
        if (bus.out_ready) state_nxt = S_CHDR;
      end
      S_CHDR: begin
        out_word = {12'b0, seq, 7'b0, poke_q, addr_q};
        if (bus.out_ready) state_nxt = S_DATA;
      end
      S_DATA: begin
        out_word = data_q;
        out_eof  = 1'b1;
        if (bus.out_ready) state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (ack_match || expire) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Abort drops whatever is in flight, including a partially sent packet.
    if (clear) state_nxt = S_IDLE;
  end

  // ---------------------------------------------------------------------------
  // State, sequence and request registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      seq   <= 4'd0;
    end else begin
      state <= state_nxt;
      if (ack_match || expire) seq <= seq + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      poke_q     <= bus.cmd_poke;
      addr_q     <= bus.cmd_addr;
      data_q     <= bus.cmd_data;
      has_time_q <= bus.cmd_has_time;
      time_q     <= bus.cmd_time;
    end
  end

  // Loaded with 1 on the DATA beat so that in the k-th cycle after that beat
  // the counter reads k; expiry therefore lands exactly TIMEOUT cycles later.
  always_ff @(posedge clock) begin
    if (reset) begin
      to_cnt <= 32'd0;
    end else if ((state == S_DATA) && bus.out_ready) begin
      to_cnt <= 32'd1;
    end else if (state == S_WAIT_ACK) begin
      to_cnt <= to_cnt + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // ACK parser and readback outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      ack_cnt <= 3'd0;
    end else if (ack_active) begin
      if (in_eof)                ack_cnt <= 3'd0;
      else if (ack_idx != 3'd7)  ack_cnt <= ack_idx + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (ack_active && (ack_idx == ACK_RBH_IDX)) begin
      rb_seq_q <= bus.in_data[19:16];
      rb_sel_q <= bus.in_data[8:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rb_valid_q <= 1'b0;
      rb_data_q  <= 32'h0;
    end else begin
      rb_valid_q <= ack_match;
      if (ack_match) rb_data_q <= bus.in_data[31:0];
    end
  end

  assign bus.cmd_ready  = (state == S_IDLE);
  assign bus.busy       = (state != S_IDLE);
  assign bus.out_valid  = out_vld;
  assign bus.out_data   = {2'b00, out_eof, out_sof, out_word};
  assign bus.in_ready   = 1'b1;
  assign bus.rb_valid   = rb_valid_q;
  assign bus.rb_data    = rb_data_q;
  assign bus.rb_timeout = expire;

endmodule

// File: tb/tb_settings_fifo_master.sv
module tb_settings_fifo_master;

  localparam logic [31:0] SID = 32'hA5A5_0001;
  localparam int          TMO = 100;

  // ACK handling kinds
  localparam int K_GOOD    = 0;  // matching ACK
  localparam int K_BADSEQ  = 1;  // ACK with wrong seq, then matching ACK
  localparam int K_TIMEOUT = 2;  // no ACK; then a late ACK with the old seq
  localparam int K_BADADDR = 3;  // ACK with wrong addr, then matching ACK
  localparam int K_SHORT   = 4;  // ACK missing a line, then matching ACK
  localparam int K_RESTART = 5;  // ACK cut by a new SOF that carries the match

  logic clock = 1'b0;
  logic reset;
  logic clear;

  settings_fifo_master_if bus ();

  settings_fifo_master #(
    .XPORT_HDR (1'b1),
    .PROT_HDR  (1'b1),
    .CMD_SID   (SID),
    .TIMEOUT   (TMO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          poke;
    logic [7:0]  addr;
    logic [31:0] data;
    bit          has_time;
    logic [63:0] tstamp;
    logic [31:0] ack_data;
    int          kind;
    int          exp_lines;
    logic [15:0] exp_words;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [3:0]  model_seq;
  logic [35:0] exp_q[$];
  int          got_lines;
  logic [31:0] got_vhdr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired, got no event, want event", name);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [35:0] ln(input bit sof, input bit eof, input logic [31:0] w);
    return {2'b00, eof, sof, w};
  endfunction

  // Expected command packet, from the packet format rules.
  task automatic build_cmd(input vec_t v, input logic [3:0] s);
    int words;
    words = v.has_time ? 6 : 4;
    exp_q.delete();
    exp_q.push_back(ln(1'b1, 1'b0, 32'(words * 4)));
    exp_q.push_back(ln(1'b0, 1'b0, 32'h1000_0000 | (v.has_time ? 32'h0010_0000 : 32'h0) |
                                   (32'(s) << 16) | 32'(words)));
    exp_q.push_back(ln(1'b0, 1'b0, SID));
    if (v.has_time) begin
      exp_q.push_back(ln(1'b0, 1'b0, v.tstamp[63:32]));
      exp_q.push_back(ln(1'b0, 1'b0, v.tstamp[31:0]));
    end
    exp_q.push_back(ln(1'b0, 1'b0, (32'(s) << 16) | (32'(v.poke) << 8) | 32'(v.addr)));
    exp_q.push_back(ln(1'b0, 1'b1, v.data));
  endtask

  task automatic send_cmd(input vec_t v);
    bit done;
    done = 1'b0;
    bus.cmd_valid    = 1'b1;
    bus.cmd_poke     = v.poke;
    bus.cmd_addr     = v.addr;
    bus.cmd_data     = v.data;
    bus.cmd_has_time = v.has_time;
    bus.cmd_time     = v.tstamp;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clock);
      if (bus.cmd_ready) done = 1'b1;
      tick();
    end
    bus.cmd_valid = 1'b0;
    if (!done) bound_fail("cmd_accept");
  endtask

  // Collect lines until the DUT flags EOF; returns just after the EOF beat edge.
  task automatic recv_cmd(input bit rnd_ready);
    bit eof_seen;
    eof_seen  = 1'b0;
    got_lines = 0;
    got_vhdr  = 32'h0;
    for (int c = 0; c < 100 && !eof_seen; c++) begin
      bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clock);
      if (c == 0) check("busy_in_tx", {bus.busy, bus.cmd_ready}, 2'b10);
      if (bus.out_valid && bus.out_ready) begin
        if (got_lines < exp_q.size()) check("cmd_line", bus.out_data, exp_q[got_lines]);
        if (got_lines == 1) got_vhdr = bus.out_data[31:0];
        got_lines++;
        if (bus.out_data[33] || got_lines > 16) eof_seen = 1'b1;
      end
      tick();
    end
    bus.out_ready = 1'b0;
    if (!eof_seen) bound_fail("cmd_eof");
  endtask

  task automatic send_ack(input logic [3:0] s, input bit poke, input logic [7:0] addr,
                          input logic [31:0] d, input int mode);
    logic [35:0] q[$];
    q.push_back(ln(1'b1, 1'b0, 32'h0000_0010));
    q.push_back(ln(1'b0, 1'b0, 32'h1000_0004 | (32'(s) << 16)));
    if (mode != 2) begin
      if (mode != 1) q.push_back(ln(1'b0, 1'b0, SID));
      q.push_back(ln(1'b0, 1'b0, (32'(s) << 16) | (32'(poke) << 8) | 32'(addr)));
      q.push_back(ln(1'b0, 1'b1, d));
    end
    foreach (q[i]) begin
      if ($urandom_range(0, 1) == 1) begin
        bus.in_valid = 1'b0;
        tick();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = q[i];
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_done(input logic [31:0] d);
    @(negedge clock);
    check("rb_valid_pulse", bus.rb_valid, 1'b1);
    check("rb_data", bus.rb_data, d);
    check("busy_after_ack", bus.busy, 1'b0);
    tick();
    @(negedge clock);
    check("rb_valid_one_cycle", bus.rb_valid, 1'b0);
    tick();
    model_seq = model_seq + 4'd1;
  endtask

  task automatic expect_drop(input string name, input bit want_busy);
    bit seen;
    bit busy_bad;
    seen     = 1'b0;
    busy_bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (bus.rb_valid) seen = 1'b1;
      if (bus.busy !== want_busy) busy_bad = 1'b1;
      tick();
    end
    check(name, {seen, busy_bad}, 2'b00);
  endtask

  task automatic run_txn(input vec_t v, input bit rnd_ready, input bit tbl_checks);
    logic [3:0] s;
    int first;
    int pulses;
    bit busy_after;
    s = model_seq;
    build_cmd(v, s);
    send_cmd(v);
    recv_cmd(rnd_ready);
    if (tbl_checks) begin
      check("line_count", got_lines, v.exp_lines);
      check("vhdr_words", got_vhdr[15:0], v.exp_words);
    end
    case (v.kind)
      K_BADSEQ: begin
        send_ack(s + 4'd2, v.poke, v.addr, v.ack_data ^ 32'hFFFF, 0);
        expect_drop("badseq_drop", 1'b1);
        send_ack(s, v.poke, v.addr, v.ack_data, 0);
        expect_done(v.ack_data);
      end
      K_BADADDR: begin
        send_ack(s, v.poke, v.addr ^ 8'h01, v.ack_data ^ 32'hFFFF, 0);
        expect_drop("badaddr_drop", 1'b1);
        send_ack(s, v.poke, v.addr, v.ack_data, 0);
        expect_done(v.ack_data);
      end
      K_SHORT: begin
        send_ack(s, v.poke, v.addr, v.ack_data ^ 32'hFFFF, 1);
        expect_drop("short_drop", 1'b1);
        send_ack(s, v.poke, v.addr, v.ack_data, 0);
        expect_done(v.ack_data);
      end
      K_RESTART: begin
        send_ack(s, v.poke, v.addr, v.ack_data, 2);
        send_ack(s, v.poke, v.addr, v.ack_data, 0);
        expect_done(v.ack_data);
      end
      K_TIMEOUT: begin
        first      = -1;
        pulses     = 0;
        busy_after = 1'b1;
        // Cycle k here is the k-th cycle after the DATA beat.
        for (int k = 1; k <= TMO + 2; k++) begin
          @(negedge clock);
          if (bus.rb_timeout) begin
            pulses++;
            if (first < 0) first = k;
          end
          if (k == TMO + 1) busy_after = bus.busy;
          tick();
        end
        check("timeout_cycle", first, TMO);
        check("timeout_pulses", pulses, 1);
        check("busy_after_timeout", busy_after, 1'b0);
        model_seq = model_seq + 4'd1;
        send_ack(s, v.poke, v.addr, v.ack_data, 0);
        expect_drop("late_ack_drop", 1'b0);
      end
      default: begin
        send_ack(s, v.poke, v.addr, v.ack_data, 0);
        expect_done(v.ack_data);
      end
    endcase
  endtask

  // Start a timed request and abort it while line `at_line` is on the bus.
  task automatic abort_at(input vec_t v, input int at_line, input bit use_reset);
    bit hit;
    hit = 1'b0;
    build_cmd(v, model_seq);
    send_cmd(v);
    for (int c = 0; c < 50 && !hit; c++) begin
      bus.out_ready = 1'b1;
      @(negedge clock);
      if (bus.out_valid && bus.out_data === exp_q[at_line]) begin
        hit = 1'b1;
        if (use_reset) reset = 1'b1;
        else           clear = 1'b1;
      end
      tick();
    end
    reset = 1'b0;
    clear = 1'b0;
    bus.out_ready = 1'b0;
    if (!hit) bound_fail("abort_line");
    @(negedge clock);
    check("abort_out_valid", bus.out_valid, 1'b0);
    check("abort_idle", {bus.cmd_ready, bus.busy, bus.rb_valid, bus.rb_timeout}, 4'b1000);
    tick();
  endtask

  vec_t tbl[7];
  vec_t v;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset            = 1'b1;
    clear            = 1'b0;
    bus.cmd_valid    = 1'b0;
    bus.cmd_poke     = 1'b0;
    bus.cmd_addr     = 8'h0;
    bus.cmd_data     = 32'h0;
    bus.cmd_has_time = 1'b0;
    bus.cmd_time     = 64'h0;
    bus.out_ready    = 1'b0;
    bus.in_data      = 36'h0;
    bus.in_valid     = 1'b0;
    model_seq        = 4'd0;

    tbl[0] = '{1'b1, 8'h12, 32'hDEADBEEF, 1'b0, 64'h0,             32'h0000_0001, K_GOOD,    5, 16'd4};
    tbl[1] = '{1'b0, 8'h03, 32'h0,        1'b1, 64'h1_0000_0010,   32'h0000_CAFE, K_GOOD,    7, 16'd6};
    tbl[2] = '{1'b1, 8'h55, 32'h12345678, 1'b0, 64'h0,             32'h0000_AAAA, K_BADSEQ,  5, 16'd4};
    tbl[3] = '{1'b0, 8'h7F, 32'h0,        1'b1, 64'hFFFFFFFF_00000001, 32'h5555_0000, K_TIMEOUT, 7, 16'd6};
    tbl[4] = '{1'b1, 8'h80, 32'hA5A5A5A5, 1'b0, 64'h0,             32'h0BAD_F00D, K_BADADDR, 5, 16'd4};
    tbl[5] = '{1'b0, 8'h01, 32'h0,        1'b1, 64'h0123_4567_89AB_CDEF, 32'h1357_9BDF, K_SHORT, 7, 16'd6};
    tbl[6] = '{1'b1, 8'hFF, 32'h0F0F0F0F, 1'b0, 64'h0,             32'hFEDC_BA98, K_RESTART, 5, 16'd4};

    repeat (3) tick();
    @(negedge clock);
    check("reset_outputs", {bus.cmd_ready, bus.out_valid, bus.rb_valid, bus.rb_timeout,
                            bus.busy, bus.in_ready}, 6'b100001);
    check("reset_rb_data", bus.rb_data, 32'h0);
    tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_txn(tbl[i], (i % 2) == 1, 1'b1);

    // Abort mid-TSF0: the next request must reuse the same seq.
    abort_at(tbl[1], 3, 1'b0);
    run_txn(tbl[0], 1'b0, 1'b1);

    for (int i = 0; i < 20; i++) begin
      v.poke      = 1'($urandom_range(0, 1));
      v.addr      = 8'($urandom);
      v.data      = $urandom;
      v.has_time  = 1'($urandom_range(0, 1));
      v.tstamp    = {$urandom, $urandom};
      v.ack_data  = $urandom;
      v.kind      = $urandom_range(0, 5);
      v.exp_lines = v.has_time ? 7 : 5;
      v.exp_words = v.has_time ? 16'd6 : 16'd4;
      run_txn(v, 1'b1, 1'b0);
    end

    // Reset mid-packet: seq returns to 0.
    abort_at(tbl[5], 2, 1'b1);
    model_seq = 4'd0;
    run_txn(tbl[2], 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
